// File: rtl/sram_read_scatterer_pkg.sv
// Shared configuration for sram_read_scatterer: FSM state encoding, default
// geometry, derived counter widths and zero-fill constants.
package sram_read_scatterer_pkg;

  localparam int unsigned DEF_DBW     = 16;
  localparam int unsigned DEF_VSIZE   = 8;
  localparam int unsigned DEF_CSIZE   = 8;
  localparam int unsigned DEF_LBW     = 10;
  localparam int unsigned DEF_ICFG_BW = 3;

  localparam int unsigned CV_BW  = $clog2(DEF_VSIZE);
  localparam int unsigned CV_BW1 = $clog2(DEF_VSIZE + 1);
  localparam int unsigned CC_BW  = $clog2(DEF_CSIZE);

  localparam logic [DEF_DBW-1:0]           ZERO_ELEM = '0;
  localparam logic [DEF_DBW*DEF_CSIZE-1:0] ZERO_LINE = '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_SCATTER
  } state_e;

endpackage

// File: rtl/sram_read_scatterer_assembler.sv
// dram_line_assembler: merges a window of an SRAM vector into the pending DRAM
// line and accumulates the lane write mask; the mask clears when the line is acked.
module dram_line_assembler #(
  parameter int DBW   = 16,
  parameter int VSIZE = 8,
  parameter int CSIZE = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_wr,
  input  logic                          i_clr,
  input  logic [DBW*VSIZE-1:0]          i_vec,
  input  logic [$clog2(VSIZE+1)-1:0]    i_src_ofs,
  input  logic [$clog2(VSIZE+1)-1:0]    i_count,
  input  logic [$clog2(CSIZE)-1:0]      i_dst_base,
  input  logic [$clog2(VSIZE+1)-1:0]    i_dst_skip,
  output logic [DBW*CSIZE-1:0]          o_line,
  output logic [CSIZE-1:0]              o_mask
);

  logic [DBW*CSIZE-1:0] line_d;
  logic [CSIZE-1:0]     mask_d;
  int unsigned          dst, src, cnt;

  always_comb begin
    line_d = o_line;
    mask_d = o_mask;
    dst    = 32'(i_dst_base) + 32'(i_dst_skip);
    src    = 32'(i_src_ofs);
    cnt    = 32'(i_count);
    if (i_clr) mask_d = '0;
    // Lane j receives vector element src + (j - dst) when it falls inside the piece.
    if (i_wr) begin
      for (int unsigned j = 0; j < CSIZE; j++) begin
        if (j >= dst && j < dst + cnt) begin
          line_d[j*DBW +: DBW] = i_vec[(src + j - dst)*DBW +: DBW];
          mask_d[j]            = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_line <= '0;
      o_mask <= '0;
    end else begin
      o_line <= line_d;
      o_mask <= mask_d;
    end
  end

endmodule

// File: rtl/sram_read_scatterer.sv
// Reads SRAM vectors per allocated tile and scatters elements into masked DRAM lines.
// Optional macro SRAM_READ_SCATTERER_RDATA_REG_EN registers i_rdata (two-cycle WAIT).
module sram_read_scatterer
  import sram_read_scatterer_pkg::*;
#(
  parameter int DBW     = DEF_DBW,
  parameter int VSIZE   = DEF_VSIZE,
  parameter int CSIZE   = DEF_CSIZE,
  parameter int LBW     = DEF_LBW,
  parameter int LBW0    = 10,
  parameter int LBW1    = 10,
  parameter int ICFG_BW = DEF_ICFG_BW
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               alloc_rdy,
  output logic                               alloc_ack,
  input  logic [ICFG_BW-1:0]                 i_id,
  input  logic [LBW:0]                       i_size,
  input  logic                               i_which,
  input  logic                               cmd_rdy,
  output logic                               cmd_ack,
  input  logic [$clog2(CSIZE)-1:0]           i_cmd_addrofs,
  input  logic [$clog2(VSIZE+1)-1:0]         i_cmd_len,
  input  logic                               i_cmd_islast,
  output logic                               r0_dval,
  output logic [LBW0-$clog2(VSIZE)-1:0]      o_raddr0,
  output logic                               r1_dval,
  output logic [LBW1-$clog2(VSIZE)-1:0]      o_raddr1,
  input  logic [DBW*VSIZE-1:0]               i_rdata,
  output logic                               dramwr_rdy,
  input  logic                               dramwr_ack,
  output logic [DBW*CSIZE-1:0]               o_dramwr,
  output logic [CSIZE-1:0]                   o_dramwr_mask,
  output logic [ICFG_BW-1:0]                 o_id
);

  localparam int VW1 = $clog2(VSIZE + 1);
  localparam logic [VW1-1:0] VSIZE_W = VW1'(VSIZE);

  state_e               state_q, state_d;
  logic [LBW:0]         size_q, consumed_q, consumed_nxt;
  logic                 which_q;
  logic [VW1-1:0]       vofs_q, handled_q, rem_cmd, rem_vec, n, vofs_nxt;
  logic [DBW*VSIZE-1:0] vec_q, rdata_src;
  logic                 proceed, cmd_done, wait_done;

`ifdef SRAM_READ_SCATTERER_RDATA_REG_EN
  logic [DBW*VSIZE-1:0] rdata_q;
  logic                 wait_q;

  // wait_q marks the second WAIT cycle, when rdata_q holds the returned vector.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rdata_q <= '0;
      wait_q  <= 1'b0;
    end else begin
      rdata_q <= i_rdata;
      wait_q  <= (state_q == ST_WAIT) && !wait_q;
    end
  end

  assign rdata_src = rdata_q;
  assign wait_done = wait_q;
`else
  assign rdata_src = i_rdata;
  assign wait_done = 1'b1;
`endif

  always_comb begin
    rem_cmd      = i_cmd_len - handled_q;
    rem_vec      = VSIZE_W - vofs_q;
    n            = (rem_cmd < rem_vec) ? rem_cmd : rem_vec;
    cmd_done     = (n == rem_cmd);
    proceed      = (state_q == ST_SCATTER) && cmd_rdy && !dramwr_rdy;
    consumed_nxt = consumed_q + {{(LBW + 1 - VW1){1'b0}}, n};
    vofs_nxt     = vofs_q + n;
    alloc_ack    = (state_q == ST_IDLE) && alloc_rdy && !i_rst;
    cmd_ack      = proceed && cmd_done;
    r0_dval      = (state_q == ST_FETCH) && !which_q;
    r1_dval      = (state_q == ST_FETCH) && which_q;
    state_d      = state_q;
    case (state_q)
      ST_IDLE:    if (alloc_ack) state_d = ST_FETCH;
      ST_FETCH:   state_d = ST_WAIT;
      ST_WAIT:    if (wait_done) state_d = ST_SCATTER;
      ST_SCATTER: begin
        if (proceed) begin
          if (consumed_nxt == size_q)  state_d = ST_IDLE;
          else if (vofs_nxt == VSIZE_W) state_d = ST_FETCH;
        end
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      o_id       <= '0;
      size_q     <= '0;
      which_q    <= 1'b0;
      consumed_q <= '0;
      vofs_q     <= '0;
      handled_q  <= '0;
      vec_q      <= '0;
      o_raddr0   <= '0;
      o_raddr1   <= '0;
      dramwr_rdy <= 1'b0;
    end else begin
      state_q <= state_d;
      if (alloc_ack) begin
        o_id       <= i_id;
        size_q     <= i_size;
        which_q    <= i_which;
        consumed_q <= '0;
        vofs_q     <= '0;
        handled_q  <= '0;
      end
      if (state_q == ST_FETCH) begin
        if (which_q) o_raddr1 <= o_raddr1 + 1'b1;
        else         o_raddr0 <= o_raddr0 + 1'b1;
      end
      if (state_q == ST_WAIT && wait_done) vec_q <= rdata_src;
      if (proceed) begin
        consumed_q <= consumed_nxt;
        handled_q  <= cmd_done ? '0 : handled_q + n;
        vofs_q     <= (vofs_nxt == VSIZE_W) ? '0 : vofs_nxt;
      end
      if (dramwr_rdy && dramwr_ack)         dramwr_rdy <= 1'b0;
      else if (cmd_ack && i_cmd_islast)     dramwr_rdy <= 1'b1;
    end
  end

  dram_line_assembler #(
    .DBW  (DBW),
    .VSIZE(VSIZE),
    .CSIZE(CSIZE)
  ) u_assembler (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr      (proceed),
    .i_clr     (dramwr_rdy && dramwr_ack),
    .i_vec     (vec_q),
    .i_src_ofs (vofs_q),
    .i_count   (n),
    .i_dst_base(i_cmd_addrofs),
    .i_dst_skip(handled_q),
    .o_line    (o_dramwr),
    .o_mask    (o_dramwr_mask)
  );

endmodule

// File: tb/tb_sram_read_scatterer.sv
// Directed bench for sram_read_scatterer: table of tile scenarios plus
// hand-written latency, backpressure, bank-1 addressing and reset sequences.
module tb_sram_read_scatterer;
  import sram_read_scatterer_pkg::*;

  localparam int DBW = 16, VSIZE = 8, CSIZE = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              i_rst = 1'b1;
  logic              alloc_rdy = 1'b0, alloc_ack;
  logic [2:0]        i_id = '0;
  logic [10:0]       i_size = '0;
  logic              i_which = 1'b0;
  logic              cmd_rdy = 1'b0, cmd_ack;
  logic [CC_BW-1:0]  i_cmd_addrofs = '0;
  logic [CV_BW1-1:0] i_cmd_len = '0;
  logic              i_cmd_islast = 1'b0;
  logic              r0_dval, r1_dval;
  logic [6:0]        o_raddr0, o_raddr1;
  logic [127:0]      i_rdata = '0;
  logic              dramwr_rdy, dramwr_ack = 1'b0;
  logic [127:0]      o_dramwr;
  logic [7:0]        o_dramwr_mask;
  logic [2:0]        o_id;

  sram_read_scatterer #(
    .DBW(DBW), .VSIZE(VSIZE), .CSIZE(CSIZE), .LBW(10), .LBW0(10), .LBW1(10), .ICFG_BW(3)
  ) dut (
    .i_clk(clk), .i_rst(i_rst),
    .alloc_rdy(alloc_rdy), .alloc_ack(alloc_ack),
    .i_id(i_id), .i_size(i_size), .i_which(i_which),
    .cmd_rdy(cmd_rdy), .cmd_ack(cmd_ack),
    .i_cmd_addrofs(i_cmd_addrofs), .i_cmd_len(i_cmd_len), .i_cmd_islast(i_cmd_islast),
    .r0_dval(r0_dval), .o_raddr0(o_raddr0), .r1_dval(r1_dval), .o_raddr1(o_raddr1),
    .i_rdata(i_rdata),
    .dramwr_rdy(dramwr_rdy), .dramwr_ack(dramwr_ack),
    .o_dramwr(o_dramwr), .o_dramwr_mask(o_dramwr_mask), .o_id(o_id)
  );

  // SRAM contents: bank0 element e of vector a is 8a+e, bank1 is 0x100+8a+e.
  function automatic logic [127:0] vec_of(input logic [15:0] base, input logic [6:0] addr);
    logic [127:0] v;
    for (int e = 0; e < 8; e++) v[e*16 +: 16] = base + 16'(addr) * 16'd8 + 16'(e);
    return v;
  endfunction

  always @(posedge clk) begin
    if (r0_dval)      i_rdata <= vec_of(16'h0000, o_raddr0);
    else if (r1_dval) i_rdata <= vec_of(16'h0100, o_raddr1);
  end

  int d0_cnt = 0, d1_cnt = 0;
  always @(negedge clk) begin
    if (r0_dval) d0_cnt++;
    if (r1_dval) d1_cnt++;
  end

  int pass_cnt = 0, total_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1; alloc_rdy = 1'b0; cmd_rdy = 1'b0; dramwr_ack = 1'b0;
    tick(); tick();
    i_rst = 1'b0;
  endtask

  typedef struct packed {
    logic              which;
    logic [10:0]       size;
    logic [1:0]        ncmd;
    logic [2:0][2:0]   c_ofs;
    logic [2:0][3:0]   c_len;
    logic [2:0]        c_last;
    logic [1:0]        nlines;
    logic [1:0][127:0] exp_line;
    logic [1:0][7:0]   exp_mask;
  } row_t;

  function automatic row_t mk(input logic w, input logic [10:0] sz, input logic [1:0] nc,
                              input logic [2:0] o0, input logic [3:0] l0, input logic s0,
                              input logic [2:0] o1, input logic [3:0] l1, input logic s1,
                              input logic [1:0] nl, input logic [127:0] ln0, input logic [7:0] m0,
                              input logic [127:0] ln1, input logic [7:0] m1);
    row_t r = '0;
    r.which = w; r.size = sz; r.ncmd = nc;
    r.c_ofs[0] = o0; r.c_len[0] = l0; r.c_last[0] = s0;
    r.c_ofs[1] = o1; r.c_len[1] = l1; r.c_last[1] = s1;
    r.nlines = nl;
    r.exp_line[0] = ln0; r.exp_mask[0] = m0;
    r.exp_line[1] = ln1; r.exp_mask[1] = m1;
    return r;
  endfunction

  // Runs one tile: acks every line as soon as it is presented and collects them.
  task automatic run_row(input row_t r, input logic [2:0] id, input bit rst_first, input string tag);
    logic [127:0] got_line [4];
    logic [7:0]   got_mask [4];
    int ci, nl;
    bit done;
    logic s_ack, s_rdy;
    logic [127:0] s_line;
    logic [7:0] s_mask;
    if (rst_first) do_reset();
    i_id = id; i_size = r.size; i_which = r.which; alloc_rdy = 1'b1;
    settle();
    chk({tag, "_alloc_ack"}, alloc_ack, 1);
    tick();
    alloc_rdy = 1'b0;
    ci = 0; nl = 0; done = 0;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      cmd_rdy = (ci < int'(r.ncmd));
      i_cmd_addrofs = r.c_ofs[ci % 3];
      i_cmd_len = r.c_len[ci % 3];
      i_cmd_islast = r.c_last[ci % 3];
      dramwr_ack = dramwr_rdy;
      settle();
      s_ack = cmd_ack; s_rdy = dramwr_rdy; s_line = o_dramwr; s_mask = o_dramwr_mask;
      tick();
      if (s_ack) ci++;
      if (s_rdy && nl < 4) begin
        got_line[nl] = s_line; got_mask[nl] = s_mask; nl++;
      end
      done = (ci >= int'(r.ncmd)) && (nl >= int'(r.nlines));
    end
    cmd_rdy = 1'b0; dramwr_ack = 1'b0;
    chk({tag, "_completed"}, done, 1);
    chk({tag, "_nlines"}, nl, r.nlines);
    for (int k = 0; k < int'(r.nlines) && k < 2; k++) begin
      chk($sformatf("%s_line%0d", tag, k), got_line[k], r.exp_line[k]);
      chk($sformatf("%s_mask%0d", tag, k), got_mask[k], r.exp_mask[k]);
    end
    chk({tag, "_o_id"}, o_id, id);
  endtask

  row_t rows [5];

  initial begin
    rows[0] = mk(0, 8,  1, 0, 8, 1, 0, 0, 0, 1,
                 128'h0007_0006_0005_0004_0003_0002_0001_0000, 8'hFF, '0, 8'h00);
    rows[1] = mk(0, 8,  2, 5, 3, 1, 0, 5, 1, 2,
                 128'h0002_0001_0000_0000_0000_0000_0000_0000, 8'hE0,
                 128'h0002_0001_0000_0007_0006_0005_0004_0003, 8'h1F);
    rows[2] = mk(0, 12, 2, 2, 6, 1, 0, 6, 1, 2,
                 128'h0005_0004_0003_0002_0001_0000_0000_0000, 8'hFC,
                 128'h0005_0004_000B_000A_0009_0008_0007_0006, 8'h3F);
    rows[3] = mk(1, 4,  1, 3, 4, 1, 0, 0, 0, 1,
                 128'h0000_0103_0102_0101_0100_0000_0000_0000, 8'h78, '0, 8'h00);
    rows[4] = mk(0, 8,  2, 0, 3, 0, 3, 5, 1, 1,
                 128'h0007_0006_0005_0004_0003_0002_0001_0000, 8'hFF, '0, 8'h00);

    // Reset state
    do_reset();
    settle();
    chk("rst_dramwr_rdy", dramwr_rdy, 0);
    chk("rst_mask", o_dramwr_mask, 0);
    chk("rst_dramwr", o_dramwr, 0);
    chk("rst_o_id", o_id, 0);
    chk("rst_raddr0", o_raddr0, 0);
    chk("rst_raddr1", o_raddr1, 0);
    chk("rst_r0_dval", r0_dval, 0);
    chk("rst_r1_dval", r1_dval, 0);
    chk("rst_cmd_ack", cmd_ack, 0);
    chk("rst_alloc_ack", alloc_ack, 0);

    for (int i = 0; i < 5; i++) run_row(rows[i], 3'(i + 1), 1'b1, $sformatf("row%0d", i));

    // Aligned latency, then a second tile stalled behind an un-acked line
    do_reset();
    i_id = 3'd3; i_size = 11'd8; i_which = 1'b0; alloc_rdy = 1'b1;
    cmd_rdy = 1'b1; i_cmd_addrofs = 3'd0; i_cmd_len = 4'd8; i_cmd_islast = 1'b1;
    settle();
    chk("lat_alloc_ack_T", alloc_ack, 1);
    tick();
    alloc_rdy = 1'b0;
    settle();
    chk("lat_r0_dval_T1", r0_dval, 1);
    chk("lat_raddr0_T1", o_raddr0, 0);
    chk("lat_o_id_T1", o_id, 3);
    tick();
    settle();
    chk("lat_raddr0_T2", o_raddr0, 1);
    chk("lat_cmd_ack_T2", cmd_ack, 0);
    tick();
    settle();
    chk("lat_cmd_ack_T3", cmd_ack, 1);
    tick();
    i_id = 3'd4; alloc_rdy = 1'b1;
    settle();
    chk("lat_dramwr_rdy_T4", dramwr_rdy, 1);
    chk("lat_line_T4", o_dramwr, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
    chk("lat_mask_T4", o_dramwr_mask, 8'hFF);
    chk("bp_alloc_while_pending", alloc_ack, 1);
    tick();
    alloc_rdy = 1'b0;
    for (int c = 0; c < 4; c++) begin
      settle();
      chk($sformatf("bp_no_cmd_ack_%0d", c), cmd_ack, 0);
      chk($sformatf("bp_rdy_%0d", c), dramwr_rdy, 1);
      chk($sformatf("bp_line_%0d", c), o_dramwr, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
      chk($sformatf("bp_mask_%0d", c), o_dramwr_mask, 8'hFF);
      tick();
    end
    dramwr_ack = 1'b1;
    settle();
    chk("bp_no_write_in_ack_cycle", cmd_ack, 0);
    tick();
    dramwr_ack = 1'b0;
    settle();
    chk("bp_rdy_cleared", dramwr_rdy, 0);
    chk("bp_mask_cleared", o_dramwr_mask, 0);
    chk("bp_data_kept", o_dramwr, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
    chk("bp_cmd_ack_after_ack", cmd_ack, 1);
    tick();
    cmd_rdy = 1'b0;
    settle();
    chk("bp_second_rdy", dramwr_rdy, 1);
    chk("bp_second_line", o_dramwr, 128'h000F_000E_000D_000C_000B_000A_0009_0008);
    chk("bp_second_mask", o_dramwr_mask, 8'hFF);
    dramwr_ack = 1'b1;
    tick();
    dramwr_ack = 1'b0;

    // Bank 1 across two allocs: only the bank-1 counter advances
    begin
      int b0, b1;
      do_reset();
      b0 = d0_cnt; b1 = d1_cnt;
      run_row(mk(1, 8, 1, 0, 8, 1, 0, 0, 0, 1,
                 128'h0107_0106_0105_0104_0103_0102_0101_0100, 8'hFF, '0, 8'h00),
              3'd5, 1'b0, "bank1_a");
      chk("bank1_raddr1_after_a", o_raddr1, 1);
      run_row(mk(1, 8, 1, 0, 8, 1, 0, 0, 0, 1,
                 128'h010F_010E_010D_010C_010B_010A_0109_0108, 8'hFF, '0, 8'h00),
              3'd6, 1'b0, "bank1_b");
      chk("bank1_raddr1_after_b", o_raddr1, 2);
      chk("bank1_raddr0_untouched", o_raddr0, 0);
      chk("bank1_r1_pulses", d1_cnt - b1, 2);
      chk("bank1_r0_pulses", d0_cnt - b0, 0);
    end

    // Reset while SCATTER holds a pending line
    do_reset();
    i_id = 3'd7; i_size = 11'd12; i_which = 1'b0; alloc_rdy = 1'b1;
    cmd_rdy = 1'b1; i_cmd_addrofs = 3'd2; i_cmd_len = 4'd6; i_cmd_islast = 1'b1;
    tick();
    alloc_rdy = 1'b0;
    tick();
    tick();
    settle();
    chk("mid_cmd_ack_T3", cmd_ack, 1);
    tick();
    i_cmd_addrofs = 3'd0;
    settle();
    chk("mid_pending_before_rst", dramwr_rdy, 1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    settle();
    chk("mid_rst_dramwr_rdy", dramwr_rdy, 0);
    chk("mid_rst_mask", o_dramwr_mask, 0);
    chk("mid_rst_dramwr", o_dramwr, 0);
    chk("mid_rst_o_id", o_id, 0);
    chk("mid_rst_raddr0", o_raddr0, 0);
    chk("mid_rst_r0_dval", r0_dval, 0);
    chk("mid_rst_cmd_ack", cmd_ack, 0);
    chk("mid_rst_alloc_ack_idle", alloc_ack, 0);
    i_size = 11'd8; i_cmd_len = 4'd8; alloc_rdy = 1'b1;
    settle();
    chk("mid_rst_fsm_idle", alloc_ack, 1);
    tick();
    alloc_rdy = 1'b0; cmd_rdy = 1'b0;
    settle();
    chk("mid_rst_fresh_r0_dval", r0_dval, 1);
    chk("mid_rst_fresh_raddr0", o_raddr0, 0);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
